// File: rtl/MD_pkg.sv
// Shared molecular-dynamics constants and the neighbour-force output word layout.
package MD_pkg;
   localparam int MD_NUM_FILTERS     = 6;
   localparam int MD_FORCE_WIDTH     = 32;
   localparam int MD_OUT_DEPTH       = 8;
   localparam int PARTICLE_ID_WIDTH  = 9;
   localparam int NODE_ID_WIDTH      = 7;

   // Word layout as it sits in the output FIFO; force packed {z,y,x}
   typedef struct packed {
      logic [3*MD_FORCE_WIDTH-1:0]  frc;
      logic [PARTICLE_ID_WIDTH-1:0] parid;
      logic [NODE_ID_WIDTH-1:0]     node_id;
   } out_word_t;
endpackage

// File: rtl/nb_force_out_fifo.sv
// Register-based first-word-fall-through FIFO with occupancy count.
module nb_force_out_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          valid,
   output logic          full,
   output logic [AW:0]   count
);
   logic [DEPTH-1:0][W-1:0] mem;
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic                    pop_en, wr_en;

   assign valid  = (count != '0);
   assign full   = (count == (AW+1)'(DEPTH));
   assign pop_en = pop & valid;
   // A full FIFO still accepts a word when the head leaves in the same cycle
   assign wr_en  = push & (~full | pop_en);
   assign dout   = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
         if (pop_en) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !pop_en)      count <= count + 1'b1;
         else if (!wr_en && pop_en) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/nb_force_accumulator.sv
// Per-filter neighbour force accumulation (negated, saturating) with release into an output FIFO.
module nb_force_accumulator
   import MD_pkg::*;
#(
   parameter int NUM_FILTERS = MD_NUM_FILTERS,
   parameter int FORCE_WIDTH = MD_FORCE_WIDTH,
   parameter int OUT_DEPTH   = MD_OUT_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_pair_valid,
   input  logic [3*FORCE_WIDTH-1:0]     i_force,
   input  logic [NUM_FILTERS-1:0]       i_acc_reg_select,
   input  logic                         i_nb_release_flag,
   input  logic [PARTICLE_ID_WIDTH-1:0] i_nb_parid,
   input  logic [NODE_ID_WIDTH-1:0]     i_nb_node_id,
   input  logic                         i_out_ready,
   output logic                         o_out_valid,
   output logic [3*FORCE_WIDTH-1:0]     o_out_force,
   output logic [PARTICLE_ID_WIDTH-1:0] o_out_parid,
   output logic [NODE_ID_WIDTH-1:0]     o_out_node_id,
   output logic                         o_back_pressure,
   output logic                         o_overflow,
   output logic [NUM_FILTERS-1:0]       o_acc_busy
);
   localparam int FW = FORCE_WIDTH;
   localparam int OW = 3*FW + PARTICLE_ID_WIDTH + NODE_ID_WIDTH;
   localparam int AW = $clog2(OUT_DEPTH);

   logic [2:0][FW-1:0]                  frc;
   logic [NUM_FILTERS-1:0][2:0][FW-1:0] acc, acc_nxt;
   logic [NUM_FILTERS-1:0]              busy, hit;
   logic [2:0][FW-1:0]                  rel_frc;
   logic                                sel_ok, push, pop, full;
   logic [AW:0]                         count;

   assign frc = i_force;

   // Zero or multi-hot selects drop the pair entirely
   assign sel_ok = i_pair_valid && (i_acc_reg_select != '0) &&
                   ((i_acc_reg_select & (i_acc_reg_select - 1'b1)) == '0);
   assign hit    = i_acc_reg_select & {NUM_FILTERS{sel_ok}};
   assign push   = sel_ok & i_nb_release_flag;

   for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_slot
      for (genvar c = 0; c < 3; c++) begin : g_comp
         logic [FW:0] d;
         // acc - force in FW+1 bits never wraps; clamp back into FW
         assign d = {acc[k][c][FW-1], acc[k][c]} - {frc[c][FW-1], frc[c]};
         assign acc_nxt[k][c] = (d[FW] == d[FW-1]) ? d[FW-1:0]
                                                   : {d[FW], {(FW-1){~d[FW]}}};
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            acc[k]  <= '0;
            busy[k] <= 1'b0;
         end else if (hit[k]) begin
            if (i_nb_release_flag) begin
               acc[k]  <= '0;
               busy[k] <= 1'b0;
            end else begin
               acc[k]  <= acc_nxt[k];
               busy[k] <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      rel_frc = '0;
      for (int k = 0; k < NUM_FILTERS; k++)
         if (hit[k]) rel_frc = rel_frc | acc_nxt[k];
   end

   assign pop = o_out_valid & i_out_ready;

   nb_force_out_fifo #(.W(OW), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   ({rel_frc, i_nb_parid, i_nb_node_id}),
      .pop   (pop),
      .dout  ({o_out_force, o_out_parid, o_out_node_id}),
      .valid (o_out_valid),
      .full  (full),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (!rst)                     o_overflow <= 1'b0;
      else if (push && full && !pop) o_overflow <= 1'b1;
   end

   assign o_back_pressure = (count >= (AW+1)'(OUT_DEPTH-2));
   assign o_acc_busy      = busy;
endmodule

// File: tb/tb_nb_force_accumulator.sv
// Directed self-checking bench for nb_force_accumulator at default parameters.
module tb_nb_force_accumulator;
   import MD_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_pair_valid;
   logic [95:0]  i_force;
   logic [5:0]   i_acc_reg_select;
   logic         i_nb_release_flag;
   logic [8:0]   i_nb_parid;
   logic [6:0]   i_nb_node_id;
   logic         i_out_ready;
   logic         o_out_valid;
   logic [95:0]  o_out_force;
   logic [8:0]   o_out_parid;
   logic [6:0]   o_out_node_id;
   logic         o_back_pressure;
   logic         o_overflow;
   logic [5:0]   o_acc_busy;

   int compared = 0;
   int mismatched = 0;

   localparam logic [5:0] S0 = 6'b000001, S1 = 6'b000010, S2 = 6'b000100,
                          S3 = 6'b001000, S4 = 6'b010000, S5 = 6'b100000;

   nb_force_accumulator dut (
      .clk(clk), .rst(rst), .i_pair_valid(i_pair_valid), .i_force(i_force),
      .i_acc_reg_select(i_acc_reg_select), .i_nb_release_flag(i_nb_release_flag),
      .i_nb_parid(i_nb_parid), .i_nb_node_id(i_nb_node_id), .i_out_ready(i_out_ready),
      .o_out_valid(o_out_valid), .o_out_force(o_out_force), .o_out_parid(o_out_parid),
      .o_out_node_id(o_out_node_id), .o_back_pressure(o_back_pressure),
      .o_overflow(o_overflow), .o_acc_busy(o_acc_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [5:0] sel, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] z, input logic rel,
                        input logic [8:0] pid, input logic [6:0] nid);
      i_pair_valid = v; i_acc_reg_select = sel; i_force = {z, y, x};
      i_nb_release_flag = rel; i_nb_parid = pid; i_nb_node_id = nid;
      @(posedge clk); #1;
      i_pair_valid = 1'b0; i_nb_release_flag = 1'b0; i_acc_reg_select = '0;
   endtask

   task automatic idle();
      drive(1'b0, '0, 0, 0, 0, 1'b0, 0, 0);
   endtask

   task automatic pop_one();
      i_out_ready = 1'b1;
      @(posedge clk); #1;
      i_out_ready = 1'b0;
   endtask

   task automatic chk_word(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z, input logic [8:0] pid, input logic [6:0] nid);
      chk({tag, ".valid"}, 32'(o_out_valid), 32'd1);
      chk({tag, ".x"}, o_out_force[31:0], x);
      chk({tag, ".y"}, o_out_force[63:32], y);
      chk({tag, ".z"}, o_out_force[95:64], z);
      chk({tag, ".parid"}, 32'(o_out_parid), 32'(pid));
      chk({tag, ".node"}, 32'(o_out_node_id), 32'(nid));
   endtask

   initial begin
      rst = 1'b0; i_pair_valid = 0; i_force = '0; i_acc_reg_select = '0;
      i_nb_release_flag = 0; i_nb_parid = '0; i_nb_node_id = '0; i_out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.valid", 32'(o_out_valid), 0);
      chk("rst.bp", 32'(o_back_pressure), 0);
      chk("rst.ovf", 32'(o_overflow), 0);
      chk("rst.busy", 32'(o_acc_busy), 0);
      chk("rst.x", o_out_force[31:0], 0);
      chk("rst.parid", 32'(o_out_parid), 0);
      rst = 1'b1;
      idle();

      // three pairs to slot 2, release on the third
      drive(1, S2, 10, -3, 0, 0, 9'h0A, 7'd1);
      chk("acc.busy2", 32'(o_acc_busy), 32'(S2));
      chk("acc.novalid", 32'(o_out_valid), 0);
      drive(1, S2, 20, 0, 7, 0, 9'h0B, 7'd2);
      drive(1, S2, 5, 0, 0, 1, 9'h11, 7'd3);
      chk_word("acc", -35, 3, -7, 9'h11, 7'd3);
      chk("acc.busy_clr", 32'(o_acc_busy), 0);
      pop_one();
      chk("acc.popped", 32'(o_out_valid), 0);

      // ignored pairs: multi-hot, invalid, zero select
      drive(1, 6'b000011, 99, 0, 0, 1, 9'h1, 7'd1);
      chk("ign.multi.valid", 32'(o_out_valid), 0);
      chk("ign.multi.busy", 32'(o_acc_busy), 0);
      drive(0, S0, 99, 0, 0, 1, 9'h1, 7'd1);
      chk("ign.novld.valid", 32'(o_out_valid), 0);
      chk("ign.novld.busy", 32'(o_acc_busy), 0);
      drive(1, '0, 99, 0, 0, 1, 9'h1, 7'd1);
      chk("ign.zero.valid", 32'(o_out_valid), 0);
      chk("ign.ovf", 32'(o_overflow), 0);

      // saturation both directions
      drive(1, S0, 32'h7FFFFFF0, 0, 32'h80000000, 0, 9'h21, 7'd4);
      drive(1, S0, 32'h7FFFFFF0, 0, 0, 1, 9'h22, 7'd5);
      chk_word("sat", 32'h80000000, 0, 32'h7FFFFFFF, 9'h22, 7'd5);
      pop_one();

      // interleaved slots 1 and 4, releases on cycles 6 and 7
      for (int c = 1; c <= 7; c++)
         drive(1, (c % 2) ? S1 : S4, 32'(c), 0, 0, c >= 6, 9'(9'h40 + c), 7'(c));
      chk_word("ilv.s4", -12, 0, 0, 9'h46, 7'd6);
      pop_one();
      chk_word("ilv.s1", -16, 0, 0, 9'h47, 7'd7);
      pop_one();
      chk("ilv.empty", 32'(o_out_valid), 0);

      // release then immediate new pair to the same slot starts from zero
      drive(1, S3, 100, 0, 0, 1, 9'h50, 7'd1);
      drive(1, S3, 7, 0, 0, 1, 9'h51, 7'd2);
      chk_word("rr.first", -100, 0, 0, 9'h50, 7'd1);
      pop_one();
      chk_word("rr.second", -7, 0, 0, 9'h51, 7'd2);
      pop_one();

      // fill to 8 watching back-pressure, then push+pop while full
      for (int i = 0; i < 8; i++) begin
         drive(1, S5, 32'(i + 1), 0, 0, 1, 9'(i), 7'(i));
         chk($sformatf("fill.bp%0d", i + 1), 32'(o_back_pressure), 32'((i + 1) >= 6));
      end
      chk("fill.ovf", 32'(o_overflow), 0);
      i_out_ready = 1'b1;
      drive(1, S5, 9, 0, 0, 1, 9'd8, 7'd8);
      i_out_ready = 1'b0;
      chk("fullpp.ovf", 32'(o_overflow), 0);
      chk("fullpp.bp", 32'(o_back_pressure), 1);
      for (int i = 0; i < 8; i++) begin
         chk_word($sformatf("fullpp.w%0d", i), -(i + 2), 0, 0, 9'(i + 1), 7'(i + 1));
         pop_one();
      end
      chk("fullpp.empty", 32'(o_out_valid), 0);
      chk("fullpp.bp0", 32'(o_back_pressure), 0);

      // overflow: 8 queued, 9th release dropped but slot still cleared
      for (int i = 0; i < 8; i++)
         drive(1, S5, 32'(i + 1), 0, 0, 1, 9'(i), 7'(i));
      drive(1, S5, 3, 0, 0, 0, 9'h70, 7'd0);
      chk("ovf.busy_set", 32'(o_acc_busy), 32'(S5));
      drive(1, S5, 100, 0, 0, 1, 9'h7F, 7'd0);
      chk("ovf.flag", 32'(o_overflow), 1);
      chk("ovf.busy_clr", 32'(o_acc_busy), 0);
      for (int i = 0; i < 8; i++) begin
         chk_word($sformatf("ovf.w%0d", i), -(i + 1), 0, 0, 9'(i), 7'(i));
         pop_one();
      end
      chk("ovf.empty", 32'(o_out_valid), 0);
      chk("ovf.sticky", 32'(o_overflow), 1);
      drive(1, S5, 1, 0, 0, 1, 9'h60, 7'd2);
      chk_word("ovf.cleared", -1, 0, 0, 9'h60, 7'd2);
      pop_one();

      // reset with 3 words queued and a partial sum in slot 1
      for (int i = 0; i < 3; i++)
         drive(1, S0, 1, 0, 0, 1, 9'(i), 7'(i));
      drive(1, S1, 50, 0, 0, 0, 9'h30, 7'd0);
      chk("mrst.busy_pre", 32'(o_acc_busy), 32'(S1));
      rst = 1'b0;
      idle();
      chk("mrst.valid", 32'(o_out_valid), 0);
      chk("mrst.ovf", 32'(o_overflow), 0);
      chk("mrst.busy", 32'(o_acc_busy), 0);
      chk("mrst.x", o_out_force[31:0], 0);
      rst = 1'b1;
      idle();
      chk("mrst.after", 32'(o_out_valid), 0);
      drive(1, S1, 4, 0, 0, 1, 9'h33, 7'd1);
      chk_word("mrst.post", -4, 0, 0, 9'h33, 7'd1);
      pop_one();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/nb_force_accumulator.md
NB_FORCE_ACCUMULATOR -- requirements
Module: nb_force_accumulator

Interface
REQ-001 Parameter NUM_FILTERS, default 6 (from MD_pkg); number of per-filter neighbour accumulator slots.
REQ-002 Parameter FORCE_WIDTH, default 32; signed fixed-point width of each force component.
REQ-003 Parameter OUT_DEPTH, default 8; depth of the output FIFO, power of 2.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset; 0 sampled at a clk edge resets the block.
REQ-006 i_pair_valid  in  1  force-pipeline result valid for one home/neighbour pair.
REQ-007 i_force  in  3*FORCE_WIDTH  {z,y,x} force on the home particle, signed.
REQ-008 i_acc_reg_select  in  NUM_FILTERS  one-hot slot select, aligned with i_pair_valid.
REQ-009 i_nb_release_flag  in  1  current pair is the last pair for the selected slot.
REQ-010 i_nb_parid  in  PARTICLE_ID_WIDTH  neighbour particle id of the current pair.
REQ-011 i_nb_node_id  in  NODE_ID_WIDTH  neighbour source node id of the current pair.
REQ-012 i_out_ready  in  1  downstream accepts the output word.
REQ-013 o_out_valid  out  1  output FIFO not empty.
REQ-014 o_out_force  out  3*FORCE_WIDTH  accumulated neighbour force.
REQ-015 o_out_parid  out  PARTICLE_ID_WIDTH; o_out_node_id  out  NODE_ID_WIDTH.
REQ-016 o_back_pressure  out  1  FIFO count >= OUT_DEPTH-2.
REQ-017 o_overflow  out  1  sticky error; a release was dropped.
REQ-018 o_acc_busy  out  NUM_FILTERS  slot holds a non-zero partial sum (pair received since last release).

Function
REQ-019 Per slot: 3 signed accumulators of FORCE_WIDTH, plus busy bit.
REQ-020 i_pair_valid=1 with i_acc_reg_select bit k: slot k accumulates -i_force (Newton's third law) per component, in the same cycle.
REQ-021 Addition saturates at the signed FORCE_WIDTH max/min; no wrap-around.
REQ-022 i_pair_valid=0: all accumulators hold; i_acc_reg_select and i_nb_release_flag ignored.
REQ-023 i_acc_reg_select zero or multi-hot with i_pair_valid=1: pair ignored; o_overflow unaffected.
REQ-024 Release (valid+flag): push {slot_sum - i_force, i_nb_parid, i_nb_node_id} into the FIFO (sum includes the current pair); slot k cleared to 0 and busy cleared the next cycle.
REQ-025 Back-to-back pairs to the same slot every cycle accumulate without loss (1-cycle read-modify-write, no hazard).
REQ-026 Release followed next cycle by a new pair to the same slot: new pair accumulates onto zero.
REQ-027 FIFO write-to-o_out_valid latency is 1 cycle; first-word-fall-through output.
REQ-028 Pop when o_out_valid & i_out_ready; push and pop in the same cycle leave count unchanged, including when full.
REQ-029 Push while full and no pop: word dropped, slot still cleared, o_overflow set until reset.
REQ-030 o_back_pressure is combinational on registered count; upstream stalls pairs when asserted.

Reset
REQ-031 On rst=0: accumulators 0, busy 0, FIFO empty, o_out_valid 0, o_back_pressure 0, o_overflow 0, o_out_force/parid/node_id 0.
REQ-032 Reset mid-operation discards all partial sums and FIFO contents; no output word appears in the cycle after reset release.

Structure
REQ-033 FORCE_WIDTH, NUM_FILTERS, OUT_DEPTH defaults and the output word packed struct (force, parid, node_id) live in MD_pkg.
REQ-034 The output FIFO is one sub-module, nb_force_out_fifo (register-based, count output); accumulation logic stays in the top module.

Verification
REQ-035 Pairs to slot 2 with force x=+10,+20,+5, release on third -> one output x=-35, parid/node_id of third pair, busy[2] 0 after.
REQ-036 Slot 0 accumulates x=0x7FFFFFF0 negated twice -> output x=0x80000000 (saturated), no wrap.
REQ-037 Interleave slots 1 and 4 each cycle, releases on cycles 6 and 7 -> two outputs in release order, correct independent sums.
REQ-038 Hold i_out_ready=0, issue 8 releases -> o_back_pressure at count 6, 9th release dropped, o_overflow=1, 8 words drained intact.
REQ-039 Full FIFO, release and pop in the same cycle -> count stays 8, no overflow, order preserved.
REQ-040 Assert rst=0 mid-accumulation with 3 words queued -> o_out_valid 0 next cycle, subsequent release outputs only post-reset pairs.
